// File: rtl/updown_counter_param.sv
// Parametrised modulo-MOD up/down counter with enable, clamped synchronous load,
// combinational terminal count and registered wrap pulse. Optional macro: UPDOWN_COUNTER_SATURATE_EN.
module updown_counter_param #(
   parameter int unsigned     WIDTH     = 4,
   parameter longint unsigned MOD       = 16,
   parameter longint unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be 1..32");
   end
   if (MOD < 2 || MOD > (64'd1 << WIDTH) || RESET_VAL >= MOD) begin : g_bad_mod
      $error("updown_counter_param: need 2 <= MOD <= 2**WIDTH and RESET_VAL < MOD");
   end

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;

   assign at_max  = (count == MAX_VAL);
   assign at_zero = (count == '0);

   // Flags the boundary for the current direction so a following stage can use tc as its enable.
   assign tc = en & (up_dn ? at_max : at_zero);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (load) begin
         count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
               count_nxt = MAX_VAL;
`else
               count_nxt = '0;
               wrap_nxt  = 1'b1;
`endif
            end else begin
               count_nxt = count + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
               count_nxt = '0;
`else
               count_nxt = MAX_VAL;
               wrap_nxt  = 1'b1;
`endif
            end else begin
               count_nxt = count - WIDTH'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= RST_VAL;
         wrap  <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
      end
   end

endmodule
